// File: rtl/rs485_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs485_pkg
// Description : Shared constants, state encoding and frame helper for the
//               RS485 9-bit multidrop poll master.
// Revision    : 1.0 - initial release
// ============================================================================
package rs485_pkg;

  // start + 8 data + flag + stop
  localparam int FRAME_BITS     = 11;
  localparam logic ADDR_FLAG    = 1'b1;
  localparam logic DATA_FLAG    = 1'b0;
  localparam int POLL_MAX_RETRY = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TX_ADDR   = 2'd1,
    WAIT_RESP = 2'd2,
    RX_FRAME  = 2'd3
  } poll_state_t;

  localparam logic [1:0] ST_IDLE      = IDLE;
  localparam logic [1:0] ST_TX_ADDR   = TX_ADDR;
  localparam logic [1:0] ST_WAIT_RESP = WAIT_RESP;
  localparam logic [1:0] ST_RX_FRAME  = RX_FRAME;

  // TX bit index of the stop bit (start = 0)
  localparam logic [3:0] TX_LAST_BIT = 4'(FRAME_BITS - 1);
  // RX bit indices counted after the start bit (data bits are 0..7)
  localparam logic [3:0] RX_FLAG_BIT = 4'd8;
  localparam logic [3:0] RX_STOP_BIT = 4'd9;

  // Serial frame image, bit 0 transmitted first.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data,
                                                        input logic       flag);
    return {1'b1, flag, data, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs485_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : rs485_frame_rx
// Description : 9-bit frame receiver. Synchronises Rx, qualifies a start bit
//               by resampling at half a bit-time, then samples mid-bit.
// Revision    : 1.0 - initial release
// Ports       : clk, reset     - clock, synchronous active-high reset
//               enable         - hunt for start bits only while high
//               rx             - asynchronous serial input, idle high
//               start_det      - 1-cycle pulse, start bit qualified
//               done           - 1-cycle pulse at the stop-bit sample
//               stop_ok        - stop-bit value, valid with done
//               flag, data     - 9th bit and received byte, valid with done
// ============================================================================
module rs485_frame_rx
  import rs485_pkg::*;
#(
  parameter int CLKS_PER_BIT = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx,
  output logic       start_det,
  output logic       done,
  output logic       stop_ok,
  output logic       flag,
  output logic [7:0] data
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);

  localparam logic [1:0] M_HUNT = 2'd0;
  localparam logic [1:0] M_QUAL = 2'd1;
  localparam logic [1:0] M_DATA = 2'd2;

  logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             flag_q, flag_d;

  always_comb begin
    sync1_d   = rx;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    flag_d    = flag_q;
    start_det = 1'b0;
    done      = 1'b0;
    if (!enable) begin
      mode_d = M_HUNT;
    end else begin
      case (mode_q)
        M_HUNT: begin
          if (prev_q && !sync2_q) begin
            mode_d = M_QUAL;
            cnt_d  = CNT_W'(1);
          end
        end
        M_QUAL: begin
          // cnt counts cycles since the first low sample; HALF_BIT is mid start bit
          if (cnt_q == HALF_BIT) begin
            if (!sync2_q) begin
              start_det = 1'b1;
              mode_d    = M_DATA;
              cnt_d     = CNT_W'(1);
              bit_d     = '0;
            end else begin
              mode_d = M_HUNT;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        M_DATA: begin
          if (cnt_q == FULL_BIT) begin
            cnt_d = CNT_W'(1);
            if (bit_q < RX_FLAG_BIT) begin
              shift_d = {sync2_q, shift_q[7:1]};
            end else if (bit_q == RX_FLAG_BIT) begin
              flag_d = sync2_q;
            end
            if (bit_q == RX_STOP_BIT) begin
              done   = 1'b1;
              mode_d = M_HUNT;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: mode_d = M_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      mode_q  <= M_HUNT;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      flag_q  <= flag_d;
    end
  end

  assign stop_ok = sync2_q;
  assign flag    = flag_q;
  assign data    = shift_q;

endmodule
`default_nettype wire

// File: rtl/rs485_poll_master.sv
`default_nettype none
// ============================================================================
// Module      : rs485_poll_master
// Description : RS485 9-bit multidrop bus master. Sends an address frame for
//               SLAVE_ADDR, releases the bus, receives two data frames (low
//               byte first) and presents the 16-bit result.
//               Optional macro POLL_RETRY_EN: re-issue the address frame up to
//               POLL_MAX_RETRY times after a timeout or framing error.
// Revision    : 1.0 - initial release
// Ports       : clk, reset           - clock, synchronous active-high reset
//               poll_req             - start a poll (sampled in IDLE only)
//               Rx                   - transceiver RO (asynchronous)
//               Tx, Tx_Enable        - transceiver DI / DE
//               poll_busy            - poll in progress
//               rx_data              - {second byte, first byte}
//               rx_valid/rx_error/timeout - 1-cycle result strobes
// ============================================================================
module rs485_poll_master
  import rs485_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR   = 8'h01,
  parameter int         CLKS_PER_BIT = 50,
  parameter int         TIMEOUT_BITS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        poll_req,
  input  logic        Rx,
  output logic        Tx,
  output logic        Tx_Enable,
  output logic        poll_busy,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        rx_error,
  output logic        timeout
);

  localparam int TXC_W   = $clog2(CLKS_PER_BIT);
  localparam int TMR_MAX = TIMEOUT_BITS * CLKS_PER_BIT - 1;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [FRAME_BITS-1:0] ADDR_FRAME = build_frame(SLAVE_ADDR, ADDR_FLAG);

  logic [1:0]            state_q, state_d;
  logic                  tx_q, tx_d, tx_en_q, tx_en_d, busy_q, busy_d;
  logic [FRAME_BITS-2:0] shift_q, shift_d;
  logic [TXC_W-1:0]      clk_cnt_q, clk_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  second_q, second_d;
  logic [7:0]            low_byte_q, low_byte_d;
  logic [15:0]           rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d, rx_error_q, rx_error_d;
  logic                  timeout_q, timeout_d;
`ifdef POLL_RETRY_EN
  logic [1:0]            retry_q, retry_d;
`endif

  logic       start_tx, fail_err, fail_tmo;
  logic       rx_enable, rx_start, rx_done, rx_stop_ok, rx_flag;
  logic [7:0] rx_byte;

  // Receiver listens only after the bus is released, so the own echo is ignored.
  assign rx_enable = (state_q == ST_WAIT_RESP) || (state_q == ST_RX_FRAME);

  rs485_frame_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_frame_rx (
    .clk      (clk),
    .reset    (reset),
    .enable   (rx_enable),
    .rx       (Rx),
    .start_det(rx_start),
    .done     (rx_done),
    .stop_ok  (rx_stop_ok),
    .flag     (rx_flag),
    .data     (rx_byte)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    tx_en_d    = tx_en_q;
    busy_d     = busy_q;
    shift_d    = shift_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tmr_d      = tmr_q;
    second_d   = second_q;
    low_byte_d = low_byte_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_error_d = 1'b0;
    timeout_d  = 1'b0;
`ifdef POLL_RETRY_EN
    retry_d    = retry_q;
`endif
    start_tx   = 1'b0;
    fail_err   = 1'b0;
    fail_tmo   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (poll_req) begin
          start_tx = 1'b1;
`ifdef POLL_RETRY_EN
          retry_d  = '0;
`endif
        end
      end
      ST_TX_ADDR: begin
        if (clk_cnt_q == TXC_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == TX_LAST_BIT) begin
            tx_d    = 1'b1;
            tx_en_d = 1'b0;
            tmr_d   = TMR_W'(TMR_MAX);
            state_d = ST_WAIT_RESP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[0];
            shift_d   = {1'b1, shift_q[FRAME_BITS-2:1]};
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      ST_WAIT_RESP: begin
        // start detection takes priority over a simultaneous expiry
        if (rx_start) begin
          state_d = ST_RX_FRAME;
        end else if (tmr_q == '0) begin
          fail_tmo = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_RX_FRAME: begin
        if (rx_done) begin
          if (rx_flag != DATA_FLAG || !rx_stop_ok) begin
            fail_err = 1'b1;
          end else if (!second_q) begin
            low_byte_d = rx_byte;
            second_d   = 1'b1;
            tmr_d      = TMR_W'(TMR_MAX);
            state_d    = ST_WAIT_RESP;
          end else begin
            rx_data_d  = {rx_byte, low_byte_q};
            rx_valid_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fail_err || fail_tmo) begin
`ifdef POLL_RETRY_EN
      if (retry_q < 2'(POLL_MAX_RETRY)) begin
        retry_d  = retry_q + 1'b1;
        start_tx = 1'b1;
      end else
`endif
      begin
        rx_error_d = fail_err;
        timeout_d  = fail_tmo;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
    end

    // Load the address frame: start bit goes out immediately, rest queued.
    if (start_tx) begin
      state_d   = ST_TX_ADDR;
      tx_d      = ADDR_FRAME[0];
      tx_en_d   = 1'b1;
      busy_d    = 1'b1;
      shift_d   = ADDR_FRAME[FRAME_BITS-1:1];
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      second_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      shift_q    <= '1;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      tmr_q      <= '0;
      second_q   <= 1'b0;
      low_byte_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef POLL_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      tx_en_q    <= tx_en_d;
      busy_q     <= busy_d;
      shift_q    <= shift_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tmr_q      <= tmr_d;
      second_q   <= second_d;
      low_byte_q <= low_byte_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_error_q <= rx_error_d;
      timeout_q  <= timeout_d;
`ifdef POLL_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign Tx        = tx_q;
  assign Tx_Enable = tx_en_q;
  assign poll_busy = busy_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_error  = rx_error_q;
  assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rs485_poll_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs485_poll_master
// Description : Self-checking bench for rs485_poll_master. Expected result
//               strobes are queued as polls are issued and checked when the
//               DUT raises rx_valid / rx_error / timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs485_poll_master;

  localparam int         CPB  = 4;
  localparam int         TOB  = 8;
  localparam logic [7:0] ADDR = 8'h01;

  // kind encoding = {rx_valid, rx_error, timeout}
  localparam logic [2:0] K_VALID   = 3'b100;
  localparam logic [2:0] K_ERROR   = 3'b010;
  localparam logic [2:0] K_TIMEOUT = 3'b001;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_exp;
  logic [2:0] mon_kind;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        poll_req = 1'b0;
  logic        Rx = 1'b1;
  logic        Tx, Tx_Enable, poll_busy, rx_valid, rx_error, timeout;
  logic [15:0] rx_data;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] model_data = 16'h0000;

  rs485_poll_master #(
    .SLAVE_ADDR  (ADDR),
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .poll_req (poll_req),
    .Rx       (Rx),
    .Tx       (Tx),
    .Tx_Enable(Tx_Enable),
    .poll_busy(poll_busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Scoreboard: every result strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && (rx_valid || rx_error || timeout)) begin
      mon_kind = {rx_valid, rx_error, timeout};
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_strobe: got kind=%b data=%h, required no strobe", mon_kind, rx_data);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_kind !== mon_exp.kind || rx_data !== mon_exp.data || poll_busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL result: got kind=%b data=%h busy=%b, required kind=%b data=%h busy=0",
                   mon_kind, rx_data, poll_busy, mon_exp.kind, mon_exp.data);
        end
      end
    end
  end

  // ---------------- stimulus helpers (no checks) ----------------
  task automatic pulse_poll();
    @(negedge clk);
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
  endtask

  task automatic wait_tx_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (Tx_Enable === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flag, input logic stop);
    logic [10:0] f;
    f = {stop, flag, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      Rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    Rx = 1'b1;
  endtask

  task automatic do_reply(input logic [7:0] b1, input logic [7:0] b2,
                          input logic stop2, input logic glitch);
    repeat (3) @(negedge clk);
    if (glitch) begin
      Rx = 1'b0;
      @(negedge clk);
      Rx = 1'b1;
      repeat (6) @(negedge clk);
    end
    send_frame(b1, 1'b0, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    send_frame(b2, 1'b0, stop2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (Tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b, required 1", Tx); end
    tests_run++;
    if (Tx_Enable !== 1'b0) begin tests_failed++; $display("FAIL reset_txen: got %b, required 0", Tx_Enable); end
    tests_run++;
    if (poll_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", poll_busy); end
    tests_run++;
    if (rx_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_data: got %h, required 0000", rx_data); end
    tests_run++;
    if ({rx_valid, rx_error, timeout} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_strobes: got %b, required 000", {rx_valid, rx_error, timeout});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_poll();
    bit ok;
    model_data = 16'h1234;
    sb.push_back('{K_VALID, 16'h1234});
    pulse_poll();
    tests_run++;
    if (poll_busy !== 1'b1) begin tests_failed++; $display("FAIL good_busy: got %b, required 1", poll_busy); end
    wait_tx_end(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL good_txend: Tx_Enable got 1, required 0 within 200 cycles"); end
    do_reply(8'h34, 8'h12, 1'b1, 1'b0);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin tests_failed++; $display("FAIL good_result: got %0d outstanding, required 0", sb.size()); end
    repeat (3) @(negedge clk);
    tests_run++;
    if (rx_data !== 16'h1234) begin tests_failed++; $display("FAIL good_hold: got %h, required 1234", rx_data); end
  endtask

  task automatic test_tx_frame_timeout();
    logic [10:0] exp_bits;
    int en_cycles;
    int wait_cnt;
    exp_bits = {1'b1, 1'b1, ADDR, 1'b0};
    sb.push_back('{K_TIMEOUT, model_data});
    pulse_poll();
    en_cycles = 0;
    while (Tx_Enable === 1'b1 && en_cycles < 100) begin
      if ((en_cycles % CPB) == 1 && (en_cycles / CPB) < 11) begin
        tests_run++;
        if (Tx !== exp_bits[en_cycles / CPB]) begin
          tests_failed++;
          $display("FAIL tx_bit%0d: got %b, required %b", en_cycles / CPB, Tx, exp_bits[en_cycles / CPB]);
        end
      end
      en_cycles++;
      @(negedge clk);
    end
    tests_run++;
    if (en_cycles != 11 * CPB) begin
      tests_failed++;
      $display("FAIL txen_width: got %0d cycles, required %0d", en_cycles, 11 * CPB);
    end
    tests_run++;
    if (Tx !== 1'b1) begin tests_failed++; $display("FAIL tx_release: got %b, required 1", Tx); end
    wait_cnt = 0;
    while (timeout !== 1'b1 && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    tests_run++;
    if (wait_cnt < TOB * CPB || wait_cnt > TOB * CPB + 2) begin
      tests_failed++;
      $display("FAIL timeout_delay: got %0d cycles, required %0d..%0d", wait_cnt, TOB * CPB, TOB * CPB + 2);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin tests_failed++; $display("FAIL timeout_result: got %0d outstanding, required 0", sb.size()); end
  endtask

  task automatic test_glitch();
    bit ok;
    model_data = 16'h5AA5;
    sb.push_back('{K_VALID, 16'h5AA5});
    pulse_poll();
    wait_tx_end(ok);
    do_reply(8'hA5, 8'h5A, 1'b1, 1'b1);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    tests_run++;
    if (!ok || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL glitch_result: got %0d outstanding (txend=%b), required 0", sb.size(), ok);
    end
  endtask

  task automatic test_frame_error();
    bit ok;
    sb.push_back('{K_ERROR, model_data});
    pulse_poll();
    wait_tx_end(ok);
    do_reply(8'h77, 8'h66, 1'b0, 1'b1);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    tests_run++;
    if (!ok || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL error_result: got %0d outstanding (txend=%b), required 0", sb.size(), ok);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (rx_data !== model_data) begin tests_failed++; $display("FAIL error_hold: got %h, required %h", rx_data, model_data); end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    int rises;
    logic prev_en;
    model_data = 16'hBEEF;
    sb.push_back('{K_VALID, 16'hBEEF});
    pulse_poll();
    repeat (10) @(negedge clk);
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    wait_tx_end(ok);
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    do_reply(8'hEF, 8'hBE, 1'b1, 1'b0);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    tests_run++;
    if (!ok || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL busy_result: got %0d outstanding (txend=%b), required 0", sb.size(), ok);
    end
    rises = 0;
    prev_en = 1'b0;
    for (int i = 0; i < 6 * CPB; i++) begin
      @(negedge clk);
      if (Tx_Enable === 1'b1 && prev_en == 1'b0) rises++;
      prev_en = Tx_Enable;
    end
    tests_run++;
    if (rises != 0 || poll_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_ignore: got %0d extra frames busy=%b, required 0 frames busy=0", rises, poll_busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    sb.push_back('{K_VALID, 16'hC3D2});
    pulse_poll();
    wait_tx_end(ok);
    do_reply(8'hD2, 8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 100 && rx_valid !== 1'b1; i++) @(negedge clk);
    model_data = 16'h0F1E;
    sb.push_back('{K_VALID, 16'h0F1E});
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    tests_run++;
    if (Tx_Enable !== 1'b1 || Tx !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_accept: got txen=%b tx=%b, required txen=1 tx=0", Tx_Enable, Tx);
    end
    wait_tx_end(ok);
    do_reply(8'h1E, 8'h0F, 1'b1, 1'b0);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    tests_run++;
    if (!ok || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_result: got %0d outstanding (txend=%b), required 0", sb.size(), ok);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    pulse_poll();
    wait_tx_end(ok);
    repeat (2) @(negedge clk);
    Rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    tests_run++;
    if (!ok || poll_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_busy: got %b (txend=%b), required 1", poll_busy, ok);
    end
    reset = 1'b1;
    @(negedge clk);
    model_data = 16'h0000;
    tests_run++;
    if (Tx !== 1'b1 || Tx_Enable !== 1'b0 || poll_busy !== 1'b0 || rx_data !== 16'h0000 ||
        {rx_valid, rx_error, timeout} !== 3'b000) begin
      tests_failed++;
      $display("FAIL mid_reset: got tx=%b en=%b busy=%b data=%h str=%b, required 1 0 0 0000 000",
               Tx, Tx_Enable, poll_busy, rx_data, {rx_valid, rx_error, timeout});
    end
    reset = 1'b0;
    Rx = 1'b1;
    repeat (TOB * CPB + 20) @(negedge clk);
    tests_run++;
    if (sb.size() != 0 || poll_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_quiet: got %0d outstanding busy=%b, required 0 busy=0", sb.size(), poll_busy);
    end
  endtask

`ifdef POLL_RETRY_EN
  task automatic test_retry();
    int rises;
    logic prev_en;
    sb.push_back('{K_TIMEOUT, model_data});
    pulse_poll();
    rises = 0;
    prev_en = 1'b0;
    for (int i = 0; i < 2000 && sb.size() != 0; i++) begin
      if (Tx_Enable === 1'b1 && prev_en == 1'b0) rises++;
      prev_en = Tx_Enable;
      @(negedge clk);
    end
    tests_run++;
    if (rises != 3) begin tests_failed++; $display("FAIL retry_frames: got %0d, required 3", rises); end
    tests_run++;
    if (sb.size() != 0) begin tests_failed++; $display("FAIL retry_result: got %0d outstanding, required 0", sb.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_poll();
`ifdef POLL_RETRY_EN
    test_retry();
`else
    test_tx_frame_timeout();
`endif
    test_glitch();
`ifndef POLL_RETRY_EN
    test_frame_error();
`endif
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
